// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: raster-scan sequencer for the conv33 3x3 datapath.
//
// Accepts a pixel stream (in_valid/in_ready), keeps two line buffers and feeds the datapath
// one window column per accepted pixel. The datapath result is captured only for interior
// window positions and presented on a valid/ready output stream.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   start, mode_in                frame start pulse (IDLE only) and kernel select latched at start
//   in_valid, in_ready, in_pixel  raster-order input pixel stream
//   conv_pix_top/mid/bot          column of the window fed to the datapath (rows row-2..row)
//   conv_shift_en, conv_mode      datapath shift strobe and kernel select
//   conv_pixel_in                 datapath result for the current window
//   out_valid, out_ready, out_pixel  filtered stream, (IMG_W-2)x(IMG_H-2) pixels per frame
//   out_last                      last output pixel of the frame (only with CONV_CTRL_TLAST_EN)
//   busy, frame_done              frame in progress / one-cycle end-of-frame pulse
//
// Optional feature: define CONV_CTRL_TLAST_EN to add the out_last output.
module conv_window_ctrl #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned IMG_W       = 64,
  parameter int unsigned IMG_H       = 64,
  parameter int unsigned COLW        = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             mode_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic [PIXEL_WIDTH-1:0] conv_pix_top,
  output logic [PIXEL_WIDTH-1:0] conv_pix_mid,
  output logic [PIXEL_WIDTH-1:0] conv_pix_bot,
  output logic                   conv_shift_en,
  output logic [1:0]             conv_mode,
  input  logic [PIXEL_WIDTH-1:0] conv_pixel_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
`ifdef CONV_CTRL_TLAST_EN
  output logic                   out_last,
`endif
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned     IdxW    = $clog2(IMG_W);
  localparam logic [COLW-1:0] ColLast = COLW'(IMG_W - 1);
  localparam logic [COLW-1:0] RowLast = COLW'(IMG_H - 1);
  localparam logic [COLW-1:0] Two     = COLW'(2);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [COLW-1:0]        row_q, row_d;
  logic [COLW-1:0]        col_q, col_d;
  logic [1:0]             mode_q, mode_d;
  logic                   win_ok_q, win_ok_d;
  logic                   out_valid_q, out_valid_d;
  logic [PIXEL_WIDTH-1:0] out_pixel_q, out_pixel_d;
  logic                   frame_done_q, frame_done_d;

  logic                   accept;
  logic                   load;
  logic [IdxW-1:0]        col_idx;

  // lb0 holds line row-1, lb1 holds line row-2; not reset, every slot is written before use.
  logic [PIXEL_WIDTH-1:0] lb0 [IMG_W];
  logic [PIXEL_WIDTH-1:0] lb1 [IMG_W];

  assign col_idx = col_q[IdxW-1:0];

  // Handshake and datapath drive
  always_comb begin
    // A captured window that cannot move into the output register blocks further shifts.
    in_ready      = (state_q == StRun) && (!win_ok_q || !out_valid_q || out_ready);
    accept        = in_valid && in_ready;
    load          = win_ok_q && (!out_valid_q || out_ready);
    conv_shift_en = accept;
    conv_pix_bot  = in_pixel;
    conv_pix_mid  = lb0[col_idx];
    conv_pix_top  = lb1[col_idx];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_idx] <= lb0[col_idx];
      lb0[col_idx] <= in_pixel;
    end
  end

  // Frame sequencing
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    mode_d       = mode_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode_in;
          row_d   = '0;
          col_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept) begin
          if (col_q == ColLast) begin
            col_d = '0;
            row_d = row_q + COLW'(1);
            if (row_q == RowLast) begin
              state_d = StFlush;
            end
          end else begin
            col_d = col_q + COLW'(1);
          end
        end
      end
      StFlush: begin
        if (!win_ok_q && !out_valid_q) begin
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Window tracking and output register
  always_comb begin
    win_ok_d    = win_ok_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    if (load) begin
      win_ok_d = 1'b0;
    end
    // Window is centred on (row-1, col-1); columns 0-1 still hold the previous line's tail.
    if (accept) begin
      win_ok_d = (row_q >= Two) && (col_q >= Two);
    end
    if (load) begin
      out_valid_d = 1'b1;
      out_pixel_d = conv_pixel_in;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      mode_q       <= '0;
      win_ok_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      mode_q       <= mode_d;
      win_ok_q     <= win_ok_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef CONV_CTRL_TLAST_EN
  logic win_last_q, win_last_d;
  logic out_last_q, out_last_d;

  // win_last follows win_ok; out_last follows out_valid.
  always_comb begin
    win_last_d = win_last_q;
    out_last_d = out_last_q;
    if (load) begin
      win_last_d = 1'b0;
    end
    if (accept) begin
      win_last_d = (row_q == RowLast) && (col_q == ColLast);
    end
    if (load) begin
      out_last_d = win_last_q;
    end else if (out_ready) begin
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_last_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      win_last_q <= win_last_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`endif

  assign conv_mode  = mode_q;
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign busy       = (state_q == StRun) || (state_q == StFlush);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: a 4x4 instance (index 0) and a 6x6 instance (index 1), each with
// a behavioural conv33 stand-in. Expected outputs come from applying the kernel to the stored
// image directly; row routing, handshake rules and frame_done timing are checked every cycle.
module tb_conv_window_ctrl;

  localparam int PW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           start_s, in_valid_s, in_ready_s, shift_s;
  logic [1:0]           out_valid_s, out_ready_s, busy_s, done_s;
  logic [1:0][1:0]      mode_in_s, conv_mode_s;
  logic [1:0][PW-1:0]   in_pix_s, top_s, mid_s, bot_s, conv_px, out_pix_s;
`ifdef CONV_CTRL_TLAST_EN
  logic [1:0]           last_s;
`endif

  conv_window_ctrl #(.PIXEL_WIDTH(PW), .IMG_W(4), .IMG_H(4), .COLW(7)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .mode_in(mode_in_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_pixel(in_pix_s[0]),
    .conv_pix_top(top_s[0]), .conv_pix_mid(mid_s[0]), .conv_pix_bot(bot_s[0]),
    .conv_shift_en(shift_s[0]), .conv_mode(conv_mode_s[0]), .conv_pixel_in(conv_px[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_pixel(out_pix_s[0]),
`ifdef CONV_CTRL_TLAST_EN
    .out_last(last_s[0]),
`endif
    .busy(busy_s[0]), .frame_done(done_s[0])
  );

  conv_window_ctrl #(.PIXEL_WIDTH(PW), .IMG_W(6), .IMG_H(6), .COLW(7)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .mode_in(mode_in_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_pixel(in_pix_s[1]),
    .conv_pix_top(top_s[1]), .conv_pix_mid(mid_s[1]), .conv_pix_bot(bot_s[1]),
    .conv_shift_en(shift_s[1]), .conv_mode(conv_mode_s[1]), .conv_pixel_in(conv_px[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_pixel(out_pix_s[1]),
`ifdef CONV_CTRL_TLAST_EN
    .out_last(last_s[1]),
`endif
    .busy(busy_s[1]), .frame_done(done_s[1])
  );

  int nrun = 0;
  int nfail = 0;
  int cyc = 0;
  int img [2][6][6];
  int exp_arr [2][16];
  int got_arr [2][16];
  int nexp [2];
  int nbeat [2];
  int acc [2];
  int int_acc [2];
  int last_cons [2];
  int exp_mode [2];
  bit fdone [2];
  bit prev_stall [2];
  int prev_pix [2];
  int prev_last [2];
  int wn [2][3][3];

  task automatic check(input string name, input int got, input int expv);
    nrun++;
    if (got != expv) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  // a b c / d e f / g h i, top row first; result clamped to 0..255
  function automatic int kern(input int m, input int a, input int b, input int c, input int d,
                              input int e, input int f, input int g, input int h, input int i);
    int v;
    case (m)
      0: v = e;
      1: v = 5 * e - b - d - f - h;
      2: v = (a + 2 * b + c + 2 * d + 4 * e + 2 * f + g + 2 * h + i) / 16;
      default: v = 8 * e - (a + b + c + d + f + g + h + i);
    endcase
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  // conv33 stand-in: 3x3 window shifted one column per shift_en, result combinational
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (shift_s[k]) begin
        for (int r = 0; r < 3; r++) begin
          wn[k][r][0] <= wn[k][r][1];
          wn[k][r][1] <= wn[k][r][2];
        end
        wn[k][0][2] <= int'(top_s[k]);
        wn[k][1][2] <= int'(mid_s[k]);
        wn[k][2][2] <= int'(bot_s[k]);
      end
    end
  end

  always_comb begin
    conv_px = '0;
    for (int k = 0; k < 2; k++) begin
      conv_px[k] = PW'(kern(int'(conv_mode_s[k]), wn[k][0][0], wn[k][0][1], wn[k][0][2],
                            wn[k][1][0], wn[k][1][1], wn[k][1][2],
                            wn[k][2][0], wn[k][2][1], wn[k][2][2]));
    end
  end

  // Per-cycle compare, sampled on the falling edge
  always @(negedge clk) begin
    int w, r, c, pend;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      w = (k == 1) ? 6 : 4;
      if (!rst_n) begin
        acc[k] = 0;
        int_acc[k] = 0;
        nbeat[k] = 0;
        prev_stall[k] = 1'b0;
      end else begin
        if (prev_stall[k]) begin
          check("hold_valid", int'(out_valid_s[k]), 1);
          check("hold_pixel", int'(out_pix_s[k]), prev_pix[k]);
`ifdef CONV_CTRL_TLAST_EN
          check("hold_last", int'(last_s[k]), prev_last[k]);
`endif
        end
        // interior windows accepted but not yet in the output register
        pend = int_acc[k] - nbeat[k] - int'(out_valid_s[k]);
        check("pending_windows", int'(pend >= 0 && pend <= 1), 1);
        if (pend == 1 && out_valid_s[k] && !out_ready_s[k])
          check("in_ready_stall", int'(in_ready_s[k]), 0);
        if (busy_s[k]) check("conv_mode", int'(conv_mode_s[k]), exp_mode[k]);
        else check("in_ready_idle", int'(in_ready_s[k]), 0);

        if (out_valid_s[k] && out_ready_s[k]) begin
          if (nbeat[k] < nexp[k]) begin
            check("out_pixel", int'(out_pix_s[k]), exp_arr[k][nbeat[k]]);
            got_arr[k][nbeat[k]] = int'(out_pix_s[k]);
`ifdef CONV_CTRL_TLAST_EN
            check("out_last", int'(last_s[k]), int'(nbeat[k] == nexp[k] - 1));
`endif
          end else begin
            check("beat_count", nbeat[k] + 1, nexp[k]);
          end
          nbeat[k]++;
          last_cons[k] = cyc;
        end

        if (done_s[k]) begin
          check("done_pixels", acc[k], w * w);
          check("done_beats", nbeat[k], nexp[k]);
          check("done_delay", cyc - last_cons[k], 2);
          fdone[k] = 1'b1;
        end

        if (shift_s[k]) begin
          r = acc[k] / w;
          c = acc[k] % w;
          if (r < w) begin
            check("pix_bot", int'(bot_s[k]), img[k][r][c]);
            if (r >= 1) check("pix_mid", int'(mid_s[k]), img[k][r-1][c]);
            if (r >= 2) check("pix_top", int'(top_s[k]), img[k][r-2][c]);
          end else begin
            check("accept_count", acc[k] + 1, w * w);
          end
          if (r >= 2 && c >= 2) int_acc[k]++;
          acc[k]++;
        end

        prev_stall[k] = out_valid_s[k] && !out_ready_s[k];
        prev_pix[k] = int'(out_pix_s[k]);
`ifdef CONV_CTRL_TLAST_EN
        prev_last[k] = int'(last_s[k]);
`endif
      end
    end
  end

  // Called and returns at posedge+2. kind: 0 ramp r*w+c, 1 constant cval, 2 random.
  // rpat: 0 out_ready always high, 1 high one cycle in four.
  task automatic run_frame(input int k, input int mode, input int kind, input int cval,
                           input int rpat, input int glitch_at, input int abort_at);
    int w, idx, t, rc;
    bit acc_now;
    w = (k == 1) ? 6 : 4;
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++)
        img[k][r][c] = (kind == 0) ? r * w + c : (kind == 1) ? cval : int'($urandom_range(0, 255));
    nexp[k] = 0;
    for (int i = 1; i < w - 1; i++) begin
      for (int j = 1; j < w - 1; j++) begin
        exp_arr[k][nexp[k]] = kern(mode, img[k][i-1][j-1], img[k][i-1][j], img[k][i-1][j+1],
                                   img[k][i][j-1], img[k][i][j], img[k][i][j+1],
                                   img[k][i+1][j-1], img[k][i+1][j], img[k][i+1][j+1]);
        nexp[k]++;
      end
    end
    for (int i = 0; i < 16; i++) got_arr[k][i] = -1;
    nbeat[k] = 0;
    acc[k] = 0;
    int_acc[k] = 0;
    fdone[k] = 1'b0;
    exp_mode[k] = mode;

    start_s[k] = 1'b1;
    mode_in_s[k] = 2'(mode);
    out_ready_s[k] = 1'b1;
    @(posedge clk); #2;
    start_s[k] = 1'b0;

    idx = 0;
    t = 0;
    rc = 0;
    while (idx < w * w && t < 1000) begin
      out_ready_s[k] = (rpat == 0) ? 1'b1 : (rc % 4 == 0);
      if (idx == abort_at) begin
        in_valid_s[k] = 1'b0;
        out_ready_s[k] = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        check("abort_out_valid", int'(out_valid_s[k]), 0);
        check("abort_busy", int'(busy_s[k]), 0);
        check("abort_frame_done", int'(done_s[k]), 0);
        return;
      end
      in_valid_s[k] = 1'b1;
      in_pix_s[k] = PW'(img[k][idx / w][idx % w]);
      start_s[k] = (idx == glitch_at);
      if (idx == glitch_at) mode_in_s[k] = 2'((mode + 1) % 4);
      #1;
      acc_now = in_ready_s[k];
      @(posedge clk); #2;
      if (acc_now) idx++;
      t++;
      rc++;
    end
    in_valid_s[k] = 1'b0;
    start_s[k] = 1'b0;
    check("all_pixels_accepted", idx, w * w);

    t = 0;
    while (!fdone[k] && t < 300) begin
      out_ready_s[k] = (rpat == 0) ? 1'b1 : (rc % 4 == 0);
      @(posedge clk); #2;
      t++;
      rc++;
    end
    check("frame_done_seen", int'(fdone[k]), 1);
    out_ready_s[k] = 1'b1;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_seq4(input int v0, input int v1, input int v2, input int v3);
    int lit [4];
    lit = '{v0, v1, v2, v3};
    check("beats_4x4", nbeat[0], 4);
    for (int i = 0; i < 4; i++) check("seq_4x4", got_arr[0][i], lit[i]);
  endtask

  task automatic check_const6(input int v);
    check("beats_6x6", nbeat[1], 16);
    for (int i = 0; i < 16; i++) check("const_6x6", got_arr[1][i], v);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_s = '0;
    in_valid_s = '0;
    out_ready_s = 2'b11;
    mode_in_s = '0;
    in_pix_s = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", int'(out_valid_s[k]), 0);
      check("rst_out_pixel", int'(out_pix_s[k]), 0);
      check("rst_conv_mode", int'(conv_mode_s[k]), 0);
      check("rst_frame_done", int'(done_s[k]), 0);
      check("rst_busy", int'(busy_s[k]), 0);
      check("rst_in_ready", int'(in_ready_s[k]), 0);
`ifdef CONV_CTRL_TLAST_EN
      check("rst_out_last", int'(last_s[k]), 0);
`endif
    end

    // ramp frame, identity kernel
    run_frame(0, 0, 0, 0, 0, -1, -1);
    check_seq4(5, 6, 9, 10);

    // constant frames on 6x6
    run_frame(1, 2, 1, 16, 0, -1, -1);
    check_const6(16);
    run_frame(1, 3, 1, 16, 0, -1, -1);
    check_const6(0);
    run_frame(1, 1, 1, 10, 0, -1, -1);
    check_const6(10);

    // random images exercise row routing through asymmetric windows
    run_frame(1, 2, 2, 0, 0, -1, -1);
    run_frame(0, 1, 2, 0, 1, -1, -1);

    // ramp frame under output backpressure
    run_frame(0, 0, 0, 0, 1, -1, -1);
    check_seq4(5, 6, 9, 10);

    // start pulse mid-frame with a different mode_in is ignored
    run_frame(0, 1, 0, 0, 0, 5, -1);
    check_seq4(5, 6, 9, 10);
    run_frame(0, 3, 0, 0, 0, -1, -1);
    check_seq4(0, 0, 0, 0);

    // reset after 7 accepted pixels, then a clean frame
    run_frame(0, 0, 0, 0, 0, -1, 7);
    repeat (3) @(posedge clk);
    #2;
    run_frame(0, 0, 0, 0, 0, -1, -1);
    check_seq4(5, 6, 9, 10);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
